// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - eight-digit seven-segment scan driver
// Double-buffered hex word and decimal points, one digit per refresh slot; new values take effect at frame wrap.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        dp_out,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      active_data_q, active_data_d;
  logic [7:0]       active_dp_q, active_dp_d;
  logic [31:0]      pending_data_q, pending_data_d;
  logic [7:0]       pending_dp_q, pending_dp_d;
  logic             pend_q, pend_d;
  logic             frame_done_q, frame_done_d;

  logic tick;
  logic boundary;

  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick && (idx_q == 3'd7);

  always_comb begin
    presc_d        = presc_q;
    idx_d          = idx_q;
    active_data_d  = active_data_q;
    active_dp_d    = active_dp_q;
    pending_data_d = pending_data_q;
    pending_dp_d   = pending_dp_q;
    pend_d         = pend_q;
    frame_done_d   = boundary;

    if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end else begin
      presc_d = presc_q + CNT_W'(1);
    end

    // At the frame boundary a simultaneous load bypasses the pending buffer so the newest word wins.
    if (boundary) begin
      if (load) begin
        active_data_d = data_in;
        active_dp_d   = dp_in;
        pend_d        = 1'b0;
      end else if (pend_q) begin
        active_data_d = pending_data_q;
        active_dp_d   = pending_dp_q;
        pend_d        = 1'b0;
      end
    end else if (load) begin
      pending_data_d = data_in;
      pending_dp_d   = dp_in;
      pend_d         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q        <= '0;
      idx_q          <= '0;
      active_data_q  <= '0;
      active_dp_q    <= '0;
      pending_data_q <= '0;
      pending_dp_q   <= '0;
      pend_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      active_data_q  <= active_data_d;
      active_dp_q    <= active_dp_d;
      pending_data_q <= pending_data_d;
      pending_dp_q   <= pending_dp_d;
      pend_q         <= pend_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Decoder anodes are wired with the index bits reversed.
  assign num        = active_data_q[4*idx_q +: 4];
  assign sel        = {idx_q[0], idx_q[1], idx_q[2]};
  assign dp_out     = ~active_dp_q[idx_q];
  assign busy       = pend_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - randomized self-checking bench for seg_scan_driver
// Reference model tracks cycles since reset and the buffered words; digit and frame position come from plain arithmetic.
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        load;
  logic        busy;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        dp_out;
  logic        frame_done;

  int vectors;
  int errors;

  int          m_cycle;
  logic [31:0] m_active;
  logic [7:0]  m_adp;
  logic [31:0] m_pending;
  logic [7:0]  m_pdp;
  logic        m_pend;

  seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
    .busy(busy), .num(num), .sel(sel), .dp_out(dp_out), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] exp_vec();
    logic [2:0] dg;
    logic       fd;
    dg = 3'((m_cycle / DIV) % 8);
    fd = (m_cycle != 0) && ((m_cycle % FRAME) == 0);
    return {4'(m_active >> (4 * dg)), dg[0], dg[1], dg[2], ~m_adp[dg], m_pend, fd};
  endfunction

  function automatic logic [9:0] obs_vec();
    return {num, sel, dp_out, busy, frame_done};
  endfunction

  // Drive one cycle of inputs, clock it, advance the model, and return 1 ns after the edge.
  task automatic step(input logic rst, input logic ld, input logic [31:0] d, input logic [7:0] dp);
    rst_n = rst; load = ld; data_in = d; dp_in = dp;
    @(posedge clk);
    if (!rst) begin
      m_cycle = 0; m_active = '0; m_adp = '0; m_pending = '0; m_pdp = '0; m_pend = 1'b0;
    end else begin
      if ((m_cycle % FRAME) == FRAME - 1) begin
        if (ld) begin
          m_active = d; m_adp = dp; m_pend = 1'b0;
        end else if (m_pend) begin
          m_active = m_pending; m_adp = m_pdp; m_pend = 1'b0;
        end
      end else if (ld) begin
        m_pending = d; m_pdp = dp; m_pend = 1'b1;
      end
      m_cycle++;
    end
    #1;
    rst_n = 1'b1; load = 1'b0; data_in = $urandom; dp_in = 8'($urandom);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 32'h0, 8'h0);
    step(1'b0, 1'b1, $urandom, 8'hFF);
    vectors++;
    if (obs_vec() !== 10'b0000_000_1_0_0) begin
      errors++;
      $display("FAIL reset_state: got %b, want %b", obs_vec(), 10'b0000_000_1_0_0);
    end
    for (int i = 0; i < 2 * FRAME + 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 8'h0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_scan cyc=%0d: got %b, want %b", m_cycle, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_load_midframe();
    while ((m_cycle % FRAME) != 10) step(1'b1, 1'b0, 32'h0, 8'h0);
    step(1'b1, 1'b1, 32'h89ABCDEF, 8'h01);
    for (int i = 0; i < 2 * FRAME; i++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL load_midframe cyc=%0d: got %b, want %b", m_cycle, obs_vec(), exp_vec());
      end
      step(1'b1, 1'b0, 32'h0, 8'h0);
    end
  endtask

  task automatic test_two_loads();
    while ((m_cycle % FRAME) != 3) step(1'b1, 1'b0, 32'h0, 8'h0);
    step(1'b1, 1'b1, 32'h11111111, 8'h00);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 32'h0, 8'h0);
    step(1'b1, 1'b1, 32'h22222222, 8'h80);
    for (int i = 0; i < 2 * FRAME; i++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL two_loads cyc=%0d: got %b, want %b", m_cycle, obs_vec(), exp_vec());
      end
      step(1'b1, 1'b0, 32'h0, 8'h0);
    end
  endtask

  task automatic test_back_to_back();
    while ((m_cycle % FRAME) != 5) step(1'b1, 1'b0, 32'h0, 8'h0);
    step(1'b1, 1'b1, 32'hAAAAAAAA, 8'hAA);
    while ((m_cycle % FRAME) != FRAME - 1) step(1'b1, 1'b0, 32'h0, 8'h0);
    step(1'b1, 1'b1, 32'h12345678, 8'h10);
    vectors++;
    if (busy !== 1'b0 || num !== 4'h8) begin
      errors++;
      $display("FAIL boundary_load: got busy=%b num=%h, want busy=0 num=8", busy, num);
    end
    for (int i = 0; i < FRAME; i++) begin
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL boundary_frame cyc=%0d: got %b, want %b", m_cycle, obs_vec(), exp_vec());
      end
      step(1'b1, 1'b0, 32'h0, 8'h0);
    end
  endtask

  task automatic test_reset_midscan();
    while ((m_cycle % FRAME) != 1) step(1'b1, 1'b0, 32'h0, 8'h0);
    step(1'b1, 1'b1, 32'h5A5A5A5A, 8'h3C);
    while ((m_cycle % FRAME) != 5 * DIV + 1) step(1'b1, 1'b0, 32'h0, 8'h0);
    step(1'b0, 1'b0, 32'h0, 8'h0);
    vectors++;
    if (obs_vec() !== 10'b0000_000_1_0_0) begin
      errors++;
      $display("FAIL reset_midscan: got %b, want %b", obs_vec(), 10'b0000_000_1_0_0);
    end
    for (int i = 0; i < DIV + 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 8'h0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_restart cyc=%0d: got %b, want %b", m_cycle, obs_vec(), exp_vec());
      end
    end
    step(1'b0, 1'b1, 32'hFFFFFFFF, 8'hFF);
    vectors++;
    if (busy !== 1'b0 || num !== 4'h0 || dp_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_with_load: got busy=%b num=%h dp=%b, want 0 0 1", busy, num, dp_out);
    end
    for (int i = 0; i < FRAME + 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 8'h0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_load_after cyc=%0d: got %b, want %b", m_cycle, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic l;
      r = ($urandom_range(0, 299) != 0);
      l = ($urandom_range(0, 9) == 0) || ((m_cycle % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 0);
      step(r, l, $urandom, 8'($urandom));
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d: got %b, want %b", m_cycle, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    vectors = 0; errors = 0;
    m_cycle = 0; m_active = '0; m_adp = '0; m_pending = '0; m_pdp = '0; m_pend = 1'b0;
    rst_n = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    test_reset();
    test_load_midframe();
    test_two_loads();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
